fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the pipelined core's FD boundary. It generates sequential PCs, issues in-order requests to a variable-latency instruction memory, and buffers returned words in a DEPTH-entry prefetch queue. It presents one {PC, instruction} pair per cycle to decode over a valid/ready handshake, and discards all in-flight and queued fetches on a redirect from execute (jump, jalr or taken branch).

## Interface
- DEPTH, 4: prefetch queue entries, and the maximum number of queued plus outstanding fetches; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IMEM_REQ  out  1  fetch request valid.
- IMEM_ADDR  out  32  fetch address; word aligned, bits [1:0]=0.
- IMEM_READY  in  1  memory accepts the request this cycle.
- IMEM_RVALID  in  1  response valid; responses return in request order.
- IMEM_RDATA  in  32  response instruction word.
- REDIRECT  in  1  flush and restart fetch.
- REDIRECT_PC  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- FD_VALID  out  1  queue head valid.
- FD_READY  in  1  decode consumes the head; this is the inverse of the decode STALL.
- FD_PC  out  32  PC of the head entry.
- FD_IR  out  32  instruction of the head entry.

## Operation
- State:
  - fetch_pc: 32 bits.
  - Queue: DEPTH × 64 bits, with rd_ptr/wr_ptr of log2(DEPTH) bits that wrap modulo DEPTH.
  - count: 0..DEPTH.
  - outstanding: 0..DEPTH.
  - drop: 0..DEPTH.
  - pc_fifo: DEPTH-entry PC tag queue that pairs each response with its address.
- Issue:
  - IMEM_REQ = !REDIRECT && (count + outstanding < DEPTH).
  - IMEM_ADDR = fetch_pc.
  - Accept = IMEM_REQ && IMEM_READY.
  - On accept: fetch_pc += 4 (wraps at 2^32), outstanding += 1, PC tag pushed.
- Response, when IMEM_RVALID is high:
  - Tag popped and outstanding -= 1.
  - If drop > 0, drop -= 1 and the data is discarded.
  - Otherwise {tag, IMEM_RDATA} is written at wr_ptr and count += 1.
- Pop: FD_VALID && FD_READY advances rd_ptr and count -= 1.
- Push and pop in the same cycle leave count unchanged.
- The credit rule guarantees the queue never overflows; no full-queue push can occur.
- Output when empty: FD_VALID=0, FD_IR=32'h0000_0013 (NOP), FD_PC=0.
- Output when not empty: FD_PC and FD_IR are combinational from the head entry.
- Redirect (highest priority):
  - count → 0 and pointers reset.
  - drop → outstanding minus the response retired this cycle, if any.
  - fetch_pc → {REDIRECT_PC[31:2], 2'b00}.
  - No request is issued and no pop is performed that cycle, regardless of FD_READY.
  - A response arriving in the redirect cycle is discarded and does not increment drop.
  - Non-dropped tags are cleared from pc_fifo; dropped responses still pop their tags.
- Requests are permitted while drop > 0. In-order return guarantees the older responses are the ones dropped.
- Handshake: IMEM_ADDR and IMEM_REQ stay stable while IMEM_REQ && !IMEM_READY, unless REDIRECT is asserted.
- Reset (asynchronous, any time):
  - fetch_pc=RESET_PC; count, outstanding and drop = 0; pointers = 0.
  - Outputs: IMEM_REQ=0, FD_VALID=0, FD_IR=NOP, FD_PC=0.
  - Any memory response pending across reset is the memory's responsibility to cancel.

## Timing
- First edge after RESET_N deasserts: IMEM_REQ=1, IMEM_ADDR=RESET_PC.
- Latency: response at edge N writes the queue; FD_VALID rises in cycle N+1. There is no bypass from IMEM_RDATA to FD_IR.
- Throughput: one instruction per cycle with single-cycle memory (RVALID the cycle after accept) and FD_READY=1.
- Redirect penalty: REDIRECT at edge R. The request for REDIRECT_PC is issued in cycle R+1. Its FD_VALID is asserted no earlier than 1 cycle after its response.
- Simultaneous REDIRECT, FD_READY and IMEM_RVALID: the redirect wins; no pop, and the response is dropped.

## Test plan
- Reset release, 1-cycle memory, FD_READY=1:
  - IMEM_ADDR sequence 0x0, 0x4, 0x8, …
  - FD_VALID high from the 3rd cycle; FD_PC increments by 4 every cycle with matching FD_IR.
- FD_READY=0, DEPTH=4:
  - Exactly 4 requests (0x0–0xC), then IMEM_REQ=0.
  - On release, pops in order 0x0, 0x4, 0x8, 0xC, then fetch resumes at 0x10.
- 3-cycle memory latency with 2 requests outstanding, REDIRECT to 0x103:
  - Both late responses are discarded; the next request address is 0x100.
  - The first FD_PC after the redirect is 0x100.
- REDIRECT in the same cycle as IMEM_RVALID, FD_VALID and FD_READY:
  - No pop and the response is dropped.
  - count=0 the next cycle, and drop equals the remaining outstanding.
- IMEM_READY held low for 5 cycles:
  - IMEM_REQ and IMEM_ADDR stay constant.
  - Fetch_pc advances only on the accepting cycle.
- RESET_N pulled low mid-stream, between clock edges:
  - FD_VALID=0 and IMEM_REQ=0 immediately, with no clock edge.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC generation, in-order imem requests,
// prefetch queue toward decode, flush on redirect.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        FD_VALID,
  input  logic        FD_READY,
  output logic [31:0] FD_PC,
  output logic [31:0] FD_IR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] pc_q, pc_d;
  ptr_t        rd_q, rd_d;
  ptr_t        wr_q, wr_d;
  ptr_t        tr_q, tr_d;
  ptr_t        tw_q, tw_d;
  cnt_t        count_q, count_d;
  cnt_t        outst_q, outst_d;
  cnt_t        drop_q, drop_d;

  logic [63:0] queue_q [DEPTH];
  logic [31:0] tag_q   [DEPTH];
  logic [63:0] head;

  logic credit;
  logic accept;
  logic rsp;
  logic keep;
  logic pop;

  // Issue credit, response retire and decode pop qualifiers.
  always_comb begin
    credit = (32'(count_q) + 32'(outst_q)) < DEPTH;
    IMEM_REQ  = RESET_N && !REDIRECT && credit;
    IMEM_ADDR = pc_q;
    accept = IMEM_REQ && IMEM_READY;
    rsp    = IMEM_RVALID && (outst_q != '0);
    keep   = rsp && !REDIRECT && (drop_q == '0);
    pop    = (count_q != '0) && FD_READY && !REDIRECT;
  end

  // Next-state: redirect flushes the queue and turns in-flight
  // fetches into drops; otherwise normal issue/retire/pop.
  always_comb begin
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    tr_d    = tr_q;
    tw_d    = tw_q;
    count_d = count_q;
    outst_d = outst_q + cnt_t'(accept) - cnt_t'(rsp);
    drop_d  = drop_q;
    if (rsp) tr_d = tr_q + ptr_t'(1);
    if (accept) tw_d = tw_q + ptr_t'(1);
    if (REDIRECT) begin
      pc_d    = REDIRECT_PC & 32'hFFFF_FFFC;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      drop_d  = outst_q - cnt_t'(rsp);
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (rsp && drop_q != '0) drop_d = drop_q - cnt_t'(1);
      if (keep) wr_d = wr_q + ptr_t'(1);
      if (pop) rd_d = rd_q + ptr_t'(1);
      count_d = count_q + cnt_t'(keep) - cnt_t'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      tr_q    <= '0;
      tw_q    <= '0;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      tr_q    <= tr_d;
      tw_q    <= tw_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // Storage: PC tags on accept, {tag, word} on kept response.
  always_ff @(posedge CLK) begin
    if (accept) tag_q[tw_q] <= pc_q;
    if (keep) queue_q[wr_q] <= {tag_q[tr_q], IMEM_RDATA};
  end

  // Head presentation; empty queue shows a NOP at PC 0.
  always_comb begin
    head     = queue_q[rd_q];
    FD_VALID = (count_q != '0);
    FD_PC    = FD_VALID ? head[63:32] : 32'h0;
    FD_IR    = FD_VALID ? head[31:0] : NOP;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random + directed stimulus against a queue-based
// reference model of the fetch unit.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        FD_VALID;
  logic        FD_READY = 1'b0;
  logic [31:0] FD_PC;
  logic [31:0] FD_IR;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_READY(IMEM_READY), .IMEM_RVALID(IMEM_RVALID),
    .IMEM_RDATA(IMEM_RDATA),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .FD_VALID(FD_VALID), .FD_READY(FD_READY),
    .FD_PC(FD_PC), .FD_IR(FD_IR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  // reference model
  ent_t        mq[$];
  logic [31:0] tags[$];
  int          drop;
  logic [31:0] m_pc;
  // memory model
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          last_due;
  int          lat_min;
  int          lat_max;

  int          cyc;
  int          n_chk;
  int          n_pass;
  logic [31:0] acc_log[$];

  function automatic logic [31:0] ir_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, got, exp, cyc);
  endtask

  task automatic model_reset();
    mq.delete();
    tags.delete();
    mem_addr.delete();
    mem_due.delete();
    drop = 0;
    m_pc = RESET_PC;
    last_due = cyc;
    acc_log.delete();
  endtask

  task automatic step(input bit rdy, input bit fdr, input bit redir,
                      input logic [31:0] rpc);
    bit          rv;
    bit          exp_req;
    int          d;
    logic [31:0] t;
    ent_t        e;
    rv = (mem_due.size() > 0) && (mem_due[0] <= cyc);
    IMEM_READY  = rdy;
    FD_READY    = fdr;
    REDIRECT    = redir;
    REDIRECT_PC = rpc;
    IMEM_RVALID = rv;
    IMEM_RDATA  = rv ? ir_of(mem_addr[0]) : $urandom;
    @(negedge CLK);
    exp_req = !redir && (mq.size() + tags.size() < DEPTH);
    chk("imem_req", {63'h0, IMEM_REQ}, {63'h0, exp_req});
    chk("imem_addr", {32'h0, IMEM_ADDR}, {32'h0, m_pc});
    chk("fd_valid", {63'h0, FD_VALID}, {63'h0, mq.size() > 0});
    chk("fd_pc", {32'h0, FD_PC},
        {32'h0, (mq.size() > 0) ? mq[0].pc : 32'h0});
    chk("fd_ir", {32'h0, FD_IR},
        {32'h0, (mq.size() > 0) ? mq[0].ir : NOP});
    if (IMEM_REQ && rdy) acc_log.push_back(IMEM_ADDR);
    if (rv) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (redir) begin
      if (rv) void'(tags.pop_front());
      drop = tags.size();
      mq.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (mq.size() > 0 && fdr) void'(mq.pop_front());
      if (rv) begin
        t = tags.pop_front();
        if (drop > 0) drop--;
        else begin
          e.pc = t;
          e.ir = ir_of(t);
          mq.push_back(e);
        end
      end
      if (exp_req && rdy) begin
        tags.push_back(m_pc);
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mem_addr.push_back(m_pc);
        mem_due.push_back(d);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Asynchronous reset asserted between edges, held two edges.
  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    chk("rst_fd_valid", {63'h0, FD_VALID}, 64'h0);
    chk("rst_imem_req", {63'h0, IMEM_REQ}, 64'h0);
    IMEM_READY = 0; IMEM_RVALID = 0; REDIRECT = 0; FD_READY = 0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    model_reset();
  endtask

  initial begin
    bit seen;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    lat_min = 1;
    lat_max = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_fd_pc", {32'h0, FD_PC}, 64'h0);
    chk("rst_fd_ir", {32'h0, FD_IR}, {32'h0, NOP});
    chk("rst_req0", {63'h0, IMEM_REQ}, 64'h0);
    RESET_N = 1'b1;
    model_reset();
    #1;
    chk("first_req", {63'h0, IMEM_REQ}, 64'h1);
    chk("first_addr", {32'h0, IMEM_ADDR}, {32'h0, RESET_PC});

    // 1-cycle memory, decode always ready
    step(1, 1, 0, 0);
    chk("p1_valid_c2", {63'h0, FD_VALID}, 64'h0);
    chk("p1_addr_c2", {32'h0, IMEM_ADDR}, 64'h4);
    step(1, 1, 0, 0);
    chk("p1_valid_c3", {63'h0, FD_VALID}, 64'h1);
    chk("p1_pc_c3", {32'h0, FD_PC}, 64'h0);
    chk("p1_addr_c3", {32'h0, IMEM_ADDR}, 64'h8);
    for (int k = 1; k <= 6; k++) begin
      step(1, 1, 0, 0);
      chk("p1_pc_seq", {32'h0, FD_PC}, 64'(4 * k));
      chk("p1_ir_seq", {32'h0, FD_IR}, {32'h0, ir_of(32'(4 * k))});
    end
    do_reset();

    // decode stalled: exactly DEPTH requests, then ordered drain
    for (int k = 0; k < 8; k++) step(1, 0, 0, 0);
    chk("p2_nreq", 64'(acc_log.size()), 64'h4);
    for (int k = 0; k < 4 && k < acc_log.size(); k++)
      chk("p2_addr", {32'h0, acc_log[k]}, 64'(4 * k));
    chk("p2_req_off", {63'h0, IMEM_REQ}, 64'h0);
    chk("p2_head", {32'h0, FD_PC}, 64'h0);
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 0, 0);
      chk("p2_drain", {32'h0, FD_PC}, 64'(4 * k));
    end
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    if (acc_log.size() >= 5) chk("p2_resume", {32'h0, acc_log[4]}, 64'h10);
    else chk("p2_resume_cnt", 64'(acc_log.size()), 64'h5);
    do_reset();

    // 3-cycle memory, redirect with two fetches in flight
    lat_min = 3;
    lat_max = 3;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h103);
    chk("p3_addr", {32'h0, IMEM_ADDR}, 64'h100);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1, 1, 0, 0);
      if (FD_VALID) begin
        seen = 1;
        chk("p3_first_pc", {32'h0, FD_PC}, 64'h100);
      end
    end
    if (!seen) chk("p3_timeout", 64'h0, 64'h1);
    do_reset();

    // redirect colliding with response and pop
    lat_min = 2;
    lat_max = 2;
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0);
    chk("p4_pre_valid", {63'h0, FD_VALID}, 64'h1);
    step(1, 1, 1, 32'h300);
    chk("p4_flushed", {63'h0, FD_VALID}, 64'h0);
    chk("p4_addr", {32'h0, IMEM_ADDR}, 64'h300);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1, 1, 0, 0);
      if (FD_VALID) begin
        seen = 1;
        chk("p4_first_pc", {32'h0, FD_PC}, 64'h300);
      end
    end
    if (!seen) chk("p4_timeout", 64'h0, 64'h1);

    // memory back-pressure
    step(0, 1, 1, 32'h200);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 0);
      chk("p5_hold_addr", {32'h0, IMEM_ADDR}, 64'h200);
      chk("p5_hold_req", {63'h0, IMEM_REQ}, 64'h1);
    end
    step(1, 1, 0, 0);
    chk("p5_advance", {32'h0, IMEM_ADDR}, 64'h204);

    // randomized traffic
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        chk("rnd_restart", {32'h0, IMEM_ADDR}, {32'h0, RESET_PC});
      end
      step($urandom_range(99) < 70, $urandom_range(99) < 70,
           $urandom_range(99) < 6, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
